// File: rtl/irrigacao_ctrl.sv
// Irrigation controller: chooses sprinkler or drip watering from the air/soil/temperature
// sensors, refills the tank on low level, and latches sensor faults until acknowledged.
//
// state       | meaning
// ------------+-------------------------------------------------
// OCIOSO      | idle, waiting for dry soil
// ASPERSAO    | sprinkler watering (Bs open)
// GOTEJAMENTO | drip watering (Vs open)
// PAUSA       | cool-down after watering
// ENCHENDO    | filling tank (En open) until high level
// ERRO        | sensor fault or fill timeout, alarm on until ack
module irrigacao_ctrl #(
   parameter int unsigned DIV     = 1000,
   parameter int unsigned T_MIN   = 10,
   parameter int unsigned T_MAX   = 60,
   parameter int unsigned T_PAUSA = 30,
   parameter int unsigned T_FILL  = 120
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       H,
   input  logic       M,
   input  logic       L,
   input  logic       Ua,
   input  logic       Us,
   input  logic       T,
   input  logic       ack,
   output logic       Bs,
   output logic       Vs,
   output logic       En,
   output logic       alarme,
   output logic [2:0] estado
);

   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      ASPERSAO    = 3'd1,
      GOTEJAMENTO = 3'd2,
      PAUSA       = 3'd3,
      ENCHENDO    = 3'd4,
      ERRO        = 3'd5
   } state_t;

   localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [7:0] T_MIN_C   = 8'(T_MIN);
   localparam logic [7:0] T_MAX_C   = 8'(T_MAX);
   localparam logic [7:0] T_PAUSA_C = 8'(T_PAUSA);
   localparam logic [7:0] T_FILL_C  = 8'(T_FILL);

   logic [6:0]       sync1_q, sync1_d;
   logic [6:0]       sync2_q, sync2_d;
   logic [1:0]       warm_q, warm_d;
   logic [CNT_W-1:0] presc_q, presc_d;
   logic [7:0]       timer_q, timer_d;
   state_t           state_q, state_d;
   logic             bs_q, bs_d;
   logic             vs_q, vs_d;
   logic             en_q, en_d;
   logic             alarme_q, alarme_d;

   logic s_h, s_m, s_l, s_ua, s_us, s_t, s_ack;
   logic fault;
   logic tick;

   assign {s_ack, s_t, s_us, s_ua, s_l, s_m, s_h} = sync2_q;
   assign fault = (s_h & ~s_m) | (s_m & ~s_l);
   assign tick  = (presc_q == CNT_LAST);

   always_comb begin
      sync1_d = {ack, T, Us, Ua, L, M, H};
      sync2_d = sync1_q;
      // FSM waits until the synchronizer holds real samples taken after reset
      warm_d  = {warm_q[0], 1'b1};
      presc_d = tick ? '0 : presc_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      if (warm_q[1]) begin
         case (state_q)
            OCIOSO: begin
               if (fault)                   state_d = ERRO;
               else if (!s_l)               state_d = ENCHENDO;
               else if (!s_us && (s_ua || s_t)) state_d = GOTEJAMENTO;
               else if (!s_us)              state_d = ASPERSAO;
            end
            ASPERSAO, GOTEJAMENTO: begin
               if (fault)                   state_d = ERRO;
               else if (!s_l)               state_d = ENCHENDO;
               else if ((s_us && (timer_q >= T_MIN_C)) || (timer_q == T_MAX_C))
                                            state_d = PAUSA;
            end
            PAUSA: begin
               if (fault)                   state_d = ERRO;
               else if (!s_l)               state_d = ENCHENDO;
               else if (timer_q == T_PAUSA_C) state_d = OCIOSO;
            end
            ENCHENDO: begin
               if (fault)                   state_d = ERRO;
               else if (s_h)                state_d = OCIOSO;
               else if (timer_q == T_FILL_C) state_d = ERRO;
            end
            ERRO: begin
               if (s_ack && !fault && s_l)  state_d = OCIOSO;
            end
            default:                        state_d = OCIOSO;
         endcase
      end
   end

   always_comb begin
      timer_d = timer_q;
      // a tick landing on a state change is dropped so the new state starts at zero
      if (state_d != state_q)
         timer_d = '0;
      else if (tick && (timer_q != 8'hFF))
         timer_d = timer_q + 8'd1;
   end

   always_comb begin
      bs_d     = (state_d == ASPERSAO);
      vs_d     = (state_d == GOTEJAMENTO);
      en_d     = (state_d == ENCHENDO);
      alarme_d = (state_d == ERRO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         warm_q   <= '0;
         presc_q  <= '0;
         timer_q  <= '0;
         state_q  <= OCIOSO;
         bs_q     <= 1'b0;
         vs_q     <= 1'b0;
         en_q     <= 1'b0;
         alarme_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         warm_q   <= warm_d;
         presc_q  <= presc_d;
         timer_q  <= timer_d;
         state_q  <= state_d;
         bs_q     <= bs_d;
         vs_q     <= vs_d;
         en_q     <= en_d;
         alarme_q <= alarme_d;
      end
   end

   assign Bs     = bs_q;
   assign Vs     = vs_q;
   assign En     = en_q;
   assign alarme = alarme_q;
   assign estado = state_q;

endmodule

// File: tb/tb_irrigacao_ctrl.sv
// Bench for irrigacao_ctrl: directed scenarios plus random sensor segments, every cycle
// compared against an edge-counting reference model of the watering rules.
module tb_irrigacao_ctrl;

   localparam int DIV = 4, T_MIN = 2, T_MAX = 5, T_PAUSA = 3, T_FILL = 6;
   localparam int S_IDLE = 0, S_ASP = 1, S_GOT = 2, S_PAUSA = 3, S_FILL = 4, S_ERR = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic H = 0, M = 0, L = 0, Ua = 0, Us = 0, T = 0, ack = 0;
   logic Bs, Vs, En, alarme;
   logic [2:0] estado;

   int n_chk = 0;
   int n_err = 0;

   int m_state, m_timer, m_edges;
   logic [6:0] m_pipe[$];

   irrigacao_ctrl #(
      .DIV(DIV), .T_MIN(T_MIN), .T_MAX(T_MAX), .T_PAUSA(T_PAUSA), .T_FILL(T_FILL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .H(H), .M(M), .L(L), .Ua(Ua), .Us(Us), .T(T), .ack(ack),
      .Bs(Bs), .Vs(Vs), .En(En), .alarme(alarme), .estado(estado)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE;
      m_timer = 0;
      m_edges = 0;
      m_pipe  = {7'd0, 7'd0};
   endtask

   // inputs reach the decision logic two edges after they are sampled
   task automatic model_edge();
      logic [6:0] v;
      logic h, m, l, ua, us, t, a;
      bit flt, tick, allow, watering_like;
      int nxt;
      v = m_pipe.pop_front();
      m_pipe.push_back({ack, T, Us, Ua, L, M, H});
      {a, t, us, ua, l, m, h} = v;
      tick  = (m_edges % DIV) == (DIV - 1);
      allow = (m_edges >= 2);
      m_edges++;
      flt = (h && !m) || (m && !l);
      watering_like = (m_state == S_IDLE) || (m_state == S_ASP) ||
                      (m_state == S_GOT) || (m_state == S_PAUSA);
      nxt = m_state;
      if (allow) begin
         if (m_state != S_ERR && flt)       nxt = S_ERR;
         else if (watering_like && !l)      nxt = S_FILL;
         else if (m_state == S_IDLE) begin
            if (!us && (ua || t))           nxt = S_GOT;
            else if (!us)                   nxt = S_ASP;
         end else if (m_state == S_ASP || m_state == S_GOT) begin
            if ((us && m_timer >= T_MIN) || m_timer == T_MAX) nxt = S_PAUSA;
         end else if (m_state == S_PAUSA) begin
            if (m_timer == T_PAUSA)         nxt = S_IDLE;
         end else if (m_state == S_FILL) begin
            if (h)                          nxt = S_IDLE;
            else if (m_timer == T_FILL)     nxt = S_ERR;
         end else if (m_state == S_ERR) begin
            if (a && !flt && l)             nxt = S_IDLE;
         end
      end
      if (nxt != m_state)  m_timer = 0;
      else if (tick && m_timer < 255) m_timer++;
      m_state = nxt;
   endtask

   task automatic compare_all();
      chk("estado", estado, m_state);
      chk("Bs", Bs, m_state == S_ASP);
      chk("Vs", Vs, m_state == S_GOT);
      chk("En", En, m_state == S_FILL);
      chk("alarme", alarme, m_state == S_ERR);
      chk("excl_bs_vs", Bs & Vs, 0);
      chk("excl_bs_en", Bs & En, 0);
      chk("excl_vs_en", Vs & En, 0);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_state(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (estado !== 3'(target) && n < budget) begin
         step();
         n++;
      end
      chk(tag, estado, target);
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lvl, hold;
      model_reset();
      #1;
      chk("rst_estado", estado, 0);
      chk("rst_Bs", Bs, 0);
      chk("rst_Vs", Vs, 0);
      chk("rst_En", En, 0);
      chk("rst_alarme", alarme, 0);
      repeat (2) @(negedge clk);
      // sprinkler: full tank, dry soil, dry air, cool
      H = 1; M = 1; L = 1; Ua = 0; T = 0; Us = 0;
      rst_n = 1'b1;
      model_reset();
      step(); step();
      chk("s1_not_early", estado, 0);
      step();
      chk("s1_asp_estado", estado, S_ASP);
      chk("s1_asp_Bs", Bs, 1);
      steps(5);
      Us = 1;
      wait_state(S_PAUSA, 40, "s1_pausa");
      wait_state(S_IDLE, 40, "s1_idle");

      // drip: humid air, T toggling must not change mode
      Us = 0; Ua = 1;
      wait_state(S_GOT, 10, "s2_got");
      for (int i = 0; i < 7; i++) begin
         T = ~T;
         step(); step();
         chk("s2_vs_hold", Vs, 1);
         chk("s2_bs_off", Bs, 0);
      end
      wait_state(S_PAUSA, 20, "s2_pausa_tmax");
      Us = 1;
      wait_state(S_IDLE, 30, "s2_idle");

      // low level during watering aborts into fill
      Us = 0; Ua = 1; T = 0;
      wait_state(S_GOT, 10, "s3_got");
      step();
      H = 0; M = 0; L = 0;
      steps(3);
      chk("s3_fill_estado", estado, S_FILL);
      chk("s3_fill_En", En, 1);
      chk("s3_fill_Vs", Vs, 0);
      Us = 1; H = 1; M = 1; L = 1;
      wait_state(S_IDLE, 10, "s3_idle");

      // fill timeout into ERRO, then ack clears it
      H = 0; M = 0; L = 0;
      wait_state(S_FILL, 10, "s4_fill");
      wait_state(S_ERR, 40, "s4_timeout");
      chk("s4_alarme", alarme, 1);
      chk("s4_En_off", En, 0);
      L = 1;
      steps(3);
      pulse_ack();
      wait_state(S_IDLE, 10, "s4_ack_idle");
      chk("s4_alarme_clr", alarme, 0);

      // sensor fault, ack ignored while it persists
      H = 1; M = 0;
      wait_state(S_ERR, 10, "s5_fault");
      pulse_ack();
      steps(5);
      chk("s5_ack_ignored", estado, S_ERR);
      M = 1;
      steps(3);
      pulse_ack();
      wait_state(S_IDLE, 10, "s5_idle");

      // async reset mid-sprinkling
      Us = 0; Ua = 0; T = 0;
      wait_state(S_ASP, 10, "s6_asp");
      steps(2);
      rst_n = 1'b0;
      #2;
      chk("s6_async_estado", estado, 0);
      chk("s6_async_Bs", Bs, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      steps(5);

      // random sensor segments
      for (int seg = 0; seg < 150; seg++) begin
         lvl = $urandom_range(0, 3);
         {H, M, L} = (lvl == 0) ? 3'b000 : (lvl == 1) ? 3'b001 :
                     (lvl == 2) ? 3'b011 : 3'b111;
         if ($urandom_range(0, 9) == 0) {H, M, L} = 3'($urandom_range(0, 7));
         Ua = 1'($urandom_range(0, 1));
         Us = 1'($urandom_range(0, 1));
         T  = 1'($urandom_range(0, 1));
         hold = $urandom_range(1, 30);
         for (int c = 0; c < hold; c++) begin
            ack = ($urandom_range(0, 7) == 0);
            step();
         end
         ack = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/irrigacao_ctrl.md
IRRIGACAO_CTRL -- requirements
Module: irrigacao_ctrl

Interface
REQ-001 Parameters, one per line:
- DIV, 1000, clock cycles per time tick (>=2)
- T_MIN, 10, minimum watering ticks
- T_MAX, 60, maximum watering ticks
- T_PAUSA, 30, cool-down ticks after watering
- T_FILL, 120, tank-fill timeout ticks
- All tick parameters are 1..255.
REQ-002 Ports, one per line:
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, reset, asynchronous, active-low
- H, in, 1, tank level high sensor
- M, in, 1, tank level mid sensor
- L, in, 1, tank level low sensor
- Ua, in, 1, air humid
- Us, in, 1, soil humid
- T, in, 1, temperature high
- ack, in, 1, operator alarm acknowledge, one-cycle pulse
- Bs, out, 1, sprinkler valve
- Vs, out, 1, drip valve
- En, out, 1, tank fill valve
- alarme, out, 1, fault indicator
- estado, out, 3, current FSM state code

Function
REQ-003 H, M, L, Ua, Us, T and ack SHALL each pass through a 2-flop synchronizer; the FSM uses only the synchronized values.
REQ-004 An input change stable before edge k SHALL affect estado at edge k+2.
REQ-005 A free-running prescaler SHALL count 0..DIV-1 and assert an internal tick for one cycle when count==DIV-1.
REQ-006 An 8-bit timer SHALL clear on every state entry, increment on tick, and saturate at 255.
REQ-007 State codes SHALL be: OCIOSO=0, ASPERSAO=1, GOTEJAMENTO=2, PAUSA=3, ENCHENDO=4, ERRO=5.
REQ-008 Sensor fault SHALL be defined as (H & ~M) | (M & ~L).
REQ-009 Transitions SHALL be evaluated each clock, in priority order; the first true condition wins.
REQ-010 Any state except ERRO: sensor fault -> ERRO.
REQ-011 OCIOSO, ASPERSAO, GOTEJAMENTO, PAUSA: ~L -> ENCHENDO (watering aborts immediately).
REQ-012 OCIOSO: ~Us & (Ua | T) -> GOTEJAMENTO; ~Us & ~Ua & ~T -> ASPERSAO; otherwise stay.
REQ-013 ASPERSAO/GOTEJAMENTO: (Us & timer>=T_MIN) | (timer==T_MAX) -> PAUSA.
REQ-014 The watering mode SHALL NOT change while watering, even if Ua or T changes.
REQ-015 PAUSA: timer==T_PAUSA -> OCIOSO.
REQ-016 ENCHENDO: H -> OCIOSO; timer==T_FILL -> ERRO.
REQ-017 ERRO: ack & no sensor fault & L -> OCIOSO; ack while the fault persists SHALL be ignored.
REQ-018 Outputs SHALL be registered Moore decodes of the state register, changing on the same edge as estado:
- Bs=1 only in ASPERSAO
- Vs=1 only in GOTEJAMENTO
- En=1 only in ENCHENDO
- alarme=1 only in ERRO
REQ-019 At most one of Bs, Vs, En SHALL be 1 in any cycle.
REQ-020 A tick coinciding with a state change SHALL NOT be counted by the new state's timer.

Reset
REQ-021 rst_n low SHALL immediately force: estado=0, Bs=Vs=En=alarme=0, timer=0, prescaler=0, synchronizer flops=0.
REQ-022 rst_n assertion mid-watering or mid-fill SHALL close all valves with no clock required.
REQ-023 After rst_n deasserts, the first state transition SHALL occur no earlier than the 3rd rising edge.

Verification
REQ-024 The bench SHALL use DIV=4, T_MIN=2, T_MAX=5, T_PAUSA=3, T_FILL=6 and cover the following scenarios:
- H=M=L=1, Ua=T=0, Us=0 -> estado=1, Bs=1 three edges later; Us=1 at tick 1 -> PAUSA only after timer reaches 2; OCIOSO after 3 more ticks.
- Full tank, Us=0, Ua=1 -> GOTEJAMENTO (Vs=1); Us held 0 -> PAUSA at timer==5 (20 cycles); toggling T mid-watering leaves Vs=1, Bs=0.
- Watering with L dropped to 0 -> Vs/Bs=0 and En=1 within 3 edges; H=1 -> OCIOSO.
- ENCHENDO with H held 0 -> ERRO after 6 ticks, alarme=1, En=0; ack with L=1 and no fault -> OCIOSO, alarme=0.
- H=1, M=0 at any state -> ERRO; ack while the fault persists -> stays ERRO.
- rst_n pulsed low mid-ASPERSAO -> Bs=0, estado=0 asynchronously; all cycles checked for Bs&Vs, Bs&En and Vs&En = 0.
